// File: rtl/godai_data_mem_responder.sv
// Data-memory responder: zero-wait req/gnt, word RAM with byte-enable stores, fixed-latency in-order responses.
// Optional grant stalling from a 16-bit LFSR is enabled by defining GODAI_DATA_MEM_GNT_STALL_EN.
module godai_data_mem_responder #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    MEM_DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                    RVALID_LATENCY  = 1,
    parameter logic [15:0]           STALL_SEED      = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    input  logic                      data_we_i,
    input  logic [DATA_WIDTH/8-1:0]   data_be_i,
    input  logic [ADDR_WIDTH-1:0]     data_addr_i,
    input  logic [DATA_WIDTH-1:0]     data_wdata_i,
    output logic [DATA_WIDTH-1:0]     data_rdata_o,
    output logic                      data_err_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    localparam int LAT   = RVALID_LATENCY;
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(MEM_DEPTH_WORDS) << 2;

    logic                   stall;
    logic                   xfer;
    logic [ADDR_WIDTH:0]    offset;
    logic                   in_range;
    logic [IDX_W-1:0]       word_idx;

    logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH_WORDS];

    logic                   s0_valid_d;
    logic                   s0_err_d;
    logic [DATA_WIDTH-1:0]  s0_rdata_d;

    logic [LAT-1:0]         valid_q;
    logic [LAT-1:0]         err_q;
    logic [DATA_WIDTH-1:0]  rdata_q [LAT];

`ifdef GODAI_DATA_MEM_GNT_STALL_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Fibonacci taps 16,14,13,11 feed bit 0; the register shifts toward the MSB.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= STALL_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign data_gnt_o = data_req_i & ~stall & rst_n;
    assign xfer       = data_gnt_o;

    // Offset is one bit wider than the address so the upper bound cannot wrap.
    assign offset   = {1'b0, data_addr_i} - {1'b0, BASE_ADDR};
    assign in_range = (data_addr_i >= BASE_ADDR) && (offset < SPAN);
    assign word_idx = offset[IDX_W+1:2];

    always_comb begin
        s0_valid_d = xfer;
        s0_err_d   = 1'b0;
        s0_rdata_d = '0;
        if (xfer) begin
            if (!in_range) begin
                s0_err_d = 1'b1;
            end else if (!data_we_i) begin
                s0_rdata_d = mem_q[word_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer && data_we_i && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (data_be_i[i]) begin
                    mem_q[word_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Response pipeline never stalls; there is no response backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < LAT; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= s0_valid_d;
            err_q[0]   <= s0_err_d;
            rdata_q[0] <= s0_rdata_d;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
            end
        end
    end

    assign data_rvalid_o = valid_q[LAT-1];
    assign data_err_o    = valid_q[LAT-1] & err_q[LAT-1];
    assign data_rdata_o  = valid_q[LAT-1] ? rdata_q[LAT-1] : '0;

endmodule
